// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction decode with register file and ID/EX register.
// Builds alu32 operands/opcode; write-back port bypasses into same-cycle reads.
module decode_stage #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] INSTR,
    input  logic         INSTR_VALID,
    output logic         INSTR_READY,
    input  logic         STALL,
    input  logic         FLUSH,
    input  logic         WB_EN,
    input  logic [M-1:0] WB_ADDR,
    input  logic [N-1:0] WB_DATA,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [3:0]   OP,
    output logic [N-1:0] STORE_DATA,
    output logic [M-1:0] DEST,
    output logic         REG_WE,
    output logic         MEM_WE,
    output logic         MEM_RD,
    output logic         VALID_OUT,
    output logic         ILLEGAL
);

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1011;
    localparam logic [3:0] ALU_SLL = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SRA = 4'b1110;

    logic [N-1:0] r_rf [2**M];

    logic [5:0]   w_opc;
    logic [5:0]   w_funct;
    logic [M-1:0] w_rs;
    logic [M-1:0] w_rt;
    logic [M-1:0] w_rd;
    logic [M-1:0] w_shamt;
    logic [15:0]  w_imm;
    logic [N-1:0] w_rs_val;
    logic [N-1:0] w_rt_val;
    logic [N-1:0] w_simm;
    logic [N-1:0] w_zimm;

    logic         w_legal;
    logic [3:0]   w_op;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_store;
    logic [M-1:0] w_dest;
    logic         w_reg_we;
    logic         w_mem_we;
    logic         w_mem_rd;

    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [3:0]   r_op;
    logic [N-1:0] r_store;
    logic [M-1:0] r_dest;
    logic         r_reg_we;
    logic         r_mem_we;
    logic         r_mem_rd;
    logic         r_valid;
    logic         r_illegal;

    assign w_opc   = INSTR[31:26];
    assign w_rs    = INSTR[25:21];
    assign w_rt    = INSTR[20:16];
    assign w_rd    = INSTR[15:11];
    assign w_shamt = INSTR[10:6];
    assign w_funct = INSTR[5:0];
    assign w_imm   = INSTR[15:0];
    assign w_simm  = {{(N-16){w_imm[15]}}, w_imm};
    assign w_zimm  = {{(N-16){1'b0}}, w_imm};

    // R0 is hard-wired; a write-back in flight wins over the stored value.
    assign w_rs_val = (w_rs == '0) ? '0 :
                      (WB_EN && WB_ADDR == w_rs) ? WB_DATA : r_rf[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 :
                      (WB_EN && WB_ADDR == w_rt) ? WB_DATA : r_rf[w_rt];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2**M; i++) r_rf[i] <= '0;
        end else if (WB_EN && WB_ADDR != '0) begin
            r_rf[WB_ADDR] <= WB_DATA;
        end
    end

    always_comb begin
        w_legal  = 1'b1;
        w_op     = ALU_ADD;
        w_a      = w_rs_val;
        w_b      = w_rt_val;
        w_store  = '0;
        w_dest   = w_rd;
        w_reg_we = 1'b1;
        w_mem_we = 1'b0;
        w_mem_rd = 1'b0;
        unique case (w_opc)
            6'h00: begin
                unique case (w_funct)
                    6'h20, 6'h21: w_op = ALU_ADD;
                    6'h22, 6'h23: w_op = ALU_SUB;
                    6'h24:        w_op = ALU_AND;
                    6'h25:        w_op = ALU_OR;
                    6'h26:        w_op = ALU_XOR;
                    6'h19:        w_op = ALU_MUL;
                    6'h00, 6'h02, 6'h03: begin
                        w_op = (w_funct == 6'h00) ? ALU_SLL :
                               (w_funct == 6'h02) ? ALU_SRL : ALU_SRA;
                        w_a  = w_rt_val;
                        w_b  = {{(N-M){1'b0}}, w_shamt};
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                w_b    = w_simm;
                w_dest = w_rt;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_op   = (w_opc == 6'h0C) ? ALU_AND :
                         (w_opc == 6'h0D) ? ALU_OR : ALU_XOR;
                w_b    = w_zimm;
                w_dest = w_rt;
            end
            6'h23: begin
                w_b      = w_simm;
                w_dest   = w_rt;
                w_mem_rd = 1'b1;
            end
            6'h2B: begin
                w_b      = w_simm;
                w_dest   = w_rt;
                w_store  = w_rt_val;
                w_reg_we = 1'b0;
                w_mem_we = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Flush outranks stall so a held slot can still be squashed.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_store   <= '0;
            r_dest    <= '0;
            r_reg_we  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (STALL) begin
            r_illegal <= 1'b0;
        end else if (INSTR_VALID && w_legal) begin
            r_a       <= w_a;
            r_b       <= w_b;
            r_op      <= w_op;
            r_store   <= w_store;
            r_dest    <= w_dest;
            r_reg_we  <= w_reg_we;
            r_mem_we  <= w_mem_we;
            r_mem_rd  <= w_mem_rd;
            r_valid   <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_store   <= '0;
            r_dest    <= '0;
            r_reg_we  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= INSTR_VALID;
        end
    end

    assign INSTR_READY = !STALL;
    assign A           = r_a;
    assign B           = r_b;
    assign OP          = r_op;
    assign STORE_DATA  = r_store;
    assign DEST        = r_dest;
    assign REG_WE      = r_reg_we;
    assign MEM_WE      = r_mem_we;
    assign MEM_RD      = r_mem_rd;
    assign VALID_OUT   = r_valid;
    assign ILLEGAL     = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage.
// Outputs are bundled and compared 1 time unit after each rising edge.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        STALL;
    logic        FLUSH;
    logic        WB_EN;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  OP;
    logic [31:0] STORE_DATA;
    logic [4:0]  DEST;
    logic        REG_WE;
    logic        MEM_WE;
    logic        MEM_RD;
    logic        VALID_OUT;
    logic        ILLEGAL;

    int n_checks = 0;
    int n_fail   = 0;

    logic [77:0] obs;
    logic [77:0] exp_v;

    localparam logic [5:0] FN [8] = '{6'h21, 6'h23, 6'h24, 6'h25,
                                      6'h26, 6'h19, 6'h00, 6'h02};
    localparam logic [3:0] FO [8] = '{4'b0100, 4'b0101, 4'b1010, 4'b1000,
                                      4'b1011, 4'b0110, 4'b1100, 4'b1101};

    decode_stage #(.N(32), .M(5)) dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .STALL(STALL), .FLUSH(FLUSH),
        .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .A(A), .B(B), .OP(OP), .STORE_DATA(STORE_DATA), .DEST(DEST),
        .REG_WE(REG_WE), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD),
        .VALID_OUT(VALID_OUT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // {A, B, OP, DEST, REG_WE, MEM_WE, MEM_RD, VALID_OUT, ILLEGAL}
    assign obs = {A, B, OP, DEST, REG_WE, MEM_WE, MEM_RD, VALID_OUT, ILLEGAL};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        WB_EN = 1'b1; WB_ADDR = addr; WB_DATA = data;
        tick();
        WB_EN = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr);
        INSTR = instr; INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        n_checks++;
        if (obs !== 78'd0 || STORE_DATA !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: got %h/%h want 0", obs, STORE_DATA);
        end
        n_checks++;
        if (INSTR_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", INSTR_READY);
        end
    endtask

    task automatic test_add();
        wb(5'd1, 32'h5);
        wb(5'd2, 32'h3);
        issue(32'h00221820);
        exp_v = {32'h5, 32'h3, 4'b0100, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL add: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_rtype();
        for (int i = 0; i < 8; i++) begin
            issue(32'h00221800 | {26'd0, FN[i]});
            if (i >= 6)
                exp_v = {32'h3, 32'h0, FO[i], 5'd3, 1'b1, 3'b001, 1'b0};
            else
                exp_v = {32'h5, 32'h3, FO[i], 5'd3, 1'b1, 3'b001, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rtype_%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_shift_imm();
        wb(5'd1, 32'h80000000);
        issue(32'h00012103);
        exp_v = {32'h80000000, 32'h4, 4'b1110, 5'd4, 1'b1, 3'b001, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL sra: got %h want %h", obs, exp_v);
        end
        issue(32'h3405FFFF);
        exp_v = {32'h0, 32'h0000FFFF, 4'b1000, 5'd5, 1'b1, 3'b001, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL ori: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_mem();
        wb(5'd1, 32'h100);
        wb(5'd6, 32'hDEADBEEF);
        issue(32'h8C26FFFC);
        exp_v = {32'h100, 32'hFFFFFFFC, 4'b0100, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lw: got %h want %h", obs, exp_v);
        end
        issue(32'hAC260008);
        exp_v = {32'h100, 32'h8, 4'b0100, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v || STORE_DATA !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw: got %h/%h want %h/deadbeef", obs, STORE_DATA, exp_v);
        end
    endtask

    task automatic test_bypass();
        WB_EN = 1'b1; WB_ADDR = 5'd7; WB_DATA = 32'h1234;
        issue(32'h00E04020);
        WB_EN = 1'b0;
        exp_v = {32'h1234, 32'h0, 4'b0100, 5'd8, 1'b1, 3'b001, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bypass: got %h want %h", obs, exp_v);
        end
        WB_EN = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'hFFFFFFFF;
        issue(32'h00074825);
        WB_EN = 1'b0;
        exp_v = {32'h0, 32'h1234, 4'b1000, 5'd9, 1'b1, 3'b001, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL r0_bypass: got %h want %h", obs, exp_v);
        end
        issue(32'h00074825);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL r0_stored: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_stall_flush();
        issue(32'h00221820);
        exp_v = {32'h100, 32'h3, 4'b0100, 5'd3, 1'b1, 3'b001, 1'b0};
        STALL = 1'b1; INSTR = 32'h00221822; INSTR_VALID = 1'b1;
        #1;
        n_checks++;
        if (INSTR_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: got %b want 0", INSTR_READY);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_v || INSTR_READY !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: got %h want %h", i, obs, exp_v);
            end
        end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        n_checks++;
        if (obs !== 78'd0 || STORE_DATA !== 32'd0) begin
            n_fail++;
            $display("FAIL flush: got %h want 0", obs);
        end
        STALL = 1'b0; INSTR_VALID = 1'b0;
        tick();
        n_checks++;
        if (obs !== 78'd0) begin
            n_fail++;
            $display("FAIL dropped: got %h want 0", obs);
        end
    endtask

    task automatic test_illegal();
        issue(32'hFC000000);
        n_checks++;
        if (obs !== 78'd1) begin
            n_fail++;
            $display("FAIL illegal_op: got %h want 1", obs);
        end
        tick();
        n_checks++;
        if (ILLEGAL !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: got %b want 0", ILLEGAL);
        end
        issue(32'h00221827);
        n_checks++;
        if (obs !== 78'd1) begin
            n_fail++;
            $display("FAIL illegal_funct: got %h want 1", obs);
        end
        STALL = 1'b1; INSTR_VALID = 1'b1;
        tick();
        STALL = 1'b0; INSTR_VALID = 1'b0;
        n_checks++;
        if (obs !== 78'd0) begin
            n_fail++;
            $display("FAIL illegal_stall: got %h want 0", obs);
        end
    endtask

    task automatic test_reset_mid();
        issue(32'h00221820);
        n_checks++;
        if (VALID_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got %b want 1", VALID_OUT);
        end
        RST = 1'b1; INSTR_VALID = 1'b1;
        WB_EN = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'h55;
        tick();
        RST = 1'b0; INSTR_VALID = 1'b0; WB_EN = 1'b0;
        n_checks++;
        if (obs !== 78'd0 || STORE_DATA !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want 0", obs);
        end
        issue(32'h00A05820);
        exp_v = {32'h0, 32'h0, 4'b0100, 5'd11, 1'b1, 3'b001, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL wb_discard: got %h want %h", obs, exp_v);
        end
    endtask

    initial begin
        RST = 1'b1; INSTR = '0; INSTR_VALID = 1'b0;
        STALL = 1'b0; FLUSH = 1'b0;
        WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        test_reset();
        test_add();
        test_rtype();
        test_shift_imm();
        test_mem();
        test_bypass();
        test_stall_flush();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
